// File: rtl/lifo_arb_pkg.sv
// lifo_arb_pkg: FSM states and operation codes shared by the LIFO access arbiter.
package lifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP = 1'b0;
endpackage

// File: rtl/lifo_access_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after i_start, wrapping modulo N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);
  logic [W:0]   w_sum;
  logic [W-1:0] w_cand;
  // Scan farthest-first so the nearest candidate to i_start is the last write
  always_comb begin
    o_found = |i_req;
    o_idx = '0;
    w_sum = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_start} + (W + 1)'(k);
      w_sum = (w_sum >= (W + 1)'(N)) ? w_sum - (W + 1)'(N) : w_sum;
      w_cand = w_sum[W-1:0];
      o_idx = i_req[w_cand] ? w_cand : o_idx;
    end
  end
endmodule

// File: rtl/lifo_access_arbiter.sv
// lifo_access_arbiter: round-robin share of a single LIFO stack among NUM_REQ requesters.
// One push/pop in flight: accept in IDLE, strobe the LIFO in EXEC, hold the response in RESP.
module lifo_access_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 2,
  parameter int REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          active_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [REQ_IDX_WIDTH-1:0]      grant_id,
  output logic                          busy,
  output logic                          lifo_wr_ins,
  output logic                          lifo_rd_ins,
  output logic [DATA_WIDTH-1:0]         lifo_data_in,
  input  logic [DATA_WIDTH-1:0]         lifo_data_out,
  input  logic                          lifo_full,
  input  logic                          lifo_empty
);
  state_t                   r_state, w_next;
  logic [REQ_IDX_WIDTH-1:0] r_rr_ptr, r_grant, w_pick;
  logic                     r_op, w_found, w_done;
  logic [DATA_WIDTH-1:0]    r_data, r_rsp_data;
  logic                     r_rsp_err;

  rr_pick #(.N(NUM_REQ), .W(REQ_IDX_WIDTH)) u_pick (
    .i_req(req_valid),
    .i_start(r_rr_ptr),
    .o_found(w_found),
    .o_idx(w_pick)
  );

  always_ff @(posedge active_clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  assign w_done = rsp_ready[r_grant];

  // rst_n gates req_ready so no accept strobe is visible while reset is held
  always_comb begin
    w_next = r_state;
    req_ready = '0;
    rsp_valid = '0;
    lifo_wr_ins = 1'b0;
    lifo_rd_ins = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready[w_pick] = w_found & rst_n;
        w_next = w_found ? EXEC : IDLE;
      end
      EXEC: begin
        lifo_wr_ins = (r_op == OP_PUSH) & ~lifo_full;
        lifo_rd_ins = (r_op == OP_POP) & ~lifo_empty;
        w_next = RESP;
      end
      RESP: begin
        rsp_valid[r_grant] = 1'b1;
        w_next = w_done ? IDLE : RESP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge active_clk or negedge rst_n)
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_grant <= '0;
      r_op <= OP_POP;
      r_data <= '0;
      r_rsp_data <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_grant <= w_pick;
        r_op <= req_op[w_pick];
        r_data <= req_data[w_pick*DATA_WIDTH +: DATA_WIDTH];
      end
      // Flags are sampled before the strobe lands; top of stack is read in the pop cycle
      if (r_state == EXEC) begin
        r_rsp_err <= (r_op == OP_PUSH) ? lifo_full : lifo_empty;
        r_rsp_data <= (r_op == OP_POP && !lifo_empty) ? lifo_data_out : '0;
      end
      if (r_state == RESP && w_done) begin
        r_rr_ptr <= (r_grant == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
        r_rsp_data <= '0;
      end
    end

  assign busy = (r_state != IDLE);
  assign grant_id = r_grant;
  assign rsp_data = r_rsp_data;
  assign rsp_err = r_rsp_err;
  assign lifo_data_in = lifo_wr_ins ? r_data : '0;
endmodule
